// File: rtl/upd_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// upd_wr_arbiter_pkg
// Shared definitions for the update-write arbiter:
//   state_t     - arbiter FSM states (IDLE, GRANT, DONE)
//   DATA_W_DEF  - default update word width
//   ADDR_W_DEF  - default word address width
//   STAT_W      - width of the optional statistics counters
//   idx_width() - bits needed to index N requesters (minimum 1)
// ---------------------------------------------------------------------------
package upd_wr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int DATA_W_DEF = 64;
   localparam int ADDR_W_DEF = 32;
   localparam int STAT_W     = 32;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/upd_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// upd_wr_arbiter_rr_pick
// Combinational round-robin finder: returns the first set bit of the
// eligible mask at or after rr_ptr, wrapping past N_REQ-1 back to 0.
// Ports:
//   eligible  in  N_REQ  requesters that may be granted
//   rr_ptr    in  IDX_W  starting index of the search
//   idx       out IDX_W  chosen requester (meaningful only when any=1)
//   any       out 1      at least one eligible requester
// ---------------------------------------------------------------------------
module upd_wr_arbiter_rr_pick
   import upd_wr_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_width(N_REQ)
)
(
   input  logic [N_REQ-1:0] eligible,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Search from the farthest offset back to offset 0 so that the last hit
   // written is the closest one to rr_ptr.
   always_comb begin
      idx  = rr_ptr;
      any  = |eligible;
      sum  = '0;
      cand = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(N_REQ)) begin
            sum = sum - (IDX_W + 1)'(N_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (eligible[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/upd_wr_arbiter.sv
// ---------------------------------------------------------------------------
// upd_wr_arbiter
// Round-robin scheduler sharing one update-write port among N_REQ update
// streams. Grants one requester at a time for up to BURST_LEN words, writes
// each word to that requester's sequential bin address, and raises
// phase_done once every requester has delivered its last word and the
// output register has drained.
//
// Optional feature: define UPD_ARB_STATS_EN to add saturating per-requester
// word counters (stat_words) and an output stall counter (stat_stalls).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cfg_base      per-requester bin base address (slice i = requester i)
//   cfg_load      load bases, clear phase state (IDLE/DONE with no pending write)
//   req_word      per-requester update word
//   req_valid     per-requester word valid
//   req_last      accepted word is the requester's final one this phase
//   req_ready     per-requester accept (combinational in mem_wr_ready)
//   mem_wr_addr   write address
//   mem_wr_data   write data
//   mem_wr_valid  write request valid
//   mem_wr_ready  memory accepts write
//   phase_done    all requesters finished and output drained
//   stat_words    (UPD_ARB_STATS_EN) words accepted per requester
//   stat_stalls   (UPD_ARB_STATS_EN) cycles with mem_wr_valid & !mem_wr_ready
// ---------------------------------------------------------------------------
module upd_wr_arbiter
   import upd_wr_arbiter_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int BURST_LEN = 8
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ*ADDR_W-1:0] cfg_base,
   input  logic                    cfg_load,
   input  logic [N_REQ*DATA_W-1:0] req_word,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic [ADDR_W-1:0]       mem_wr_addr,
   output logic [DATA_W-1:0]       mem_wr_data,
   output logic                    mem_wr_valid,
   input  logic                    mem_wr_ready,
   output logic                    phase_done
`ifdef UPD_ARB_STATS_EN
   ,
   output logic [N_REQ*STAT_W-1:0] stat_words,
   output logic [STAT_W-1:0]       stat_stalls
`endif
);

   localparam int IDX_W = idx_width(N_REQ);
   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  gnt;
   logic [IDX_W-1:0]  rr_ptr;
   logic [CNT_W-1:0]  burst_cnt;
   logic [N_REQ-1:0]  finished;
   logic [ADDR_W-1:0] wr_ptr [N_REQ];

   logic [N_REQ-1:0]  eligible;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;

   logic [DATA_W-1:0] sel_word;
   logic [ADDR_W-1:0] sel_ptr;
   logic              sel_valid;
   logic              sel_last;

   logic              slot_free;
   logic              accept;
   logic              burst_end;
   logic              load_ok;
   logic              start;

   assign eligible = req_valid & ~finished;

   upd_wr_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .idx      (pick_idx),
      .any      (pick_any)
   );

   // Granted requester's inputs and write pointer.
   always_comb begin
      sel_word  = '0;
      sel_ptr   = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDX_W'(i) == gnt) begin
            sel_word  = req_word[i*DATA_W +: DATA_W];
            sel_ptr   = wr_ptr[i];
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The output slot is free when empty or draining this cycle, which lets a
   // new word follow every cycle under continuous mem_wr_ready.
   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      phase_done = 1'b0;
      slot_free  = !mem_wr_valid || mem_wr_ready;
      accept     = 1'b0;
      burst_end  = 1'b0;
      load_ok    = 1'b0;
      start      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cfg_load && !mem_wr_valid) begin
               load_ok = 1'b1;
            end else if ((&finished) && !mem_wr_valid) begin
               state_nxt = ST_DONE;
            end else if (pick_any) begin
               start     = 1'b1;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            for (int i = 0; i < N_REQ; i++) begin
               req_ready[i] = (IDX_W'(i) == gnt) && slot_free;
            end
            accept = sel_valid && slot_free;
            if (accept && ((burst_cnt == CNT_LAST) || sel_last)) begin
               burst_end = 1'b1;
            end else if (!sel_valid && slot_free) begin
               burst_end = 1'b1;
            end
            if (burst_end) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DONE: begin
            phase_done = 1'b1;
            if (cfg_load && !mem_wr_valid) begin
               load_ok   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt          <= '0;
         rr_ptr       <= '0;
         burst_cnt    <= '0;
         finished     <= '0;
         mem_wr_valid <= 1'b0;
         mem_wr_addr  <= '0;
         mem_wr_data  <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            wr_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (load_ok) begin
               wr_ptr[i] <= cfg_base[i*ADDR_W +: ADDR_W];
            end else if (accept && (IDX_W'(i) == gnt)) begin
               wr_ptr[i] <= wr_ptr[i] + 1'b1;
            end
         end
         if (load_ok) begin
            finished <= '0;
            rr_ptr   <= '0;
         end
         if (start) begin
            gnt       <= pick_idx;
            burst_cnt <= '0;
         end
         if (accept) begin
            mem_wr_valid <= 1'b1;
            mem_wr_addr  <= sel_ptr;
            mem_wr_data  <= sel_word;
            burst_cnt    <= burst_cnt + 1'b1;
            if (sel_last) begin
               finished[gnt] <= 1'b1;
            end
         end else if (mem_wr_ready) begin
            mem_wr_valid <= 1'b0;
         end
         if (burst_end) begin
            rr_ptr <= (gnt == IDX_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
         end
      end
   end

`ifdef UPD_ARB_STATS_EN
   logic [STAT_W-1:0] word_cnt [N_REQ];
   logic [STAT_W-1:0] stall_cnt;

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst || load_ok) begin
         stall_cnt <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            word_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (accept && (IDX_W'(i) == gnt) && (word_cnt[i] != '1)) begin
               word_cnt[i] <= word_cnt[i] + 1'b1;
            end
         end
         if (mem_wr_valid && !mem_wr_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      stat_words = '0;
      for (int i = 0; i < N_REQ; i++) begin
         stat_words[i*STAT_W +: STAT_W] = word_cnt[i];
      end
   end

   assign stat_stalls = stall_cnt;
`endif

endmodule

// File: tb/tb_upd_wr_arbiter.sv
`timescale 1ns/1ps
module tb_upd_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int AW = 32;
   localparam int BL = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*AW-1:0] cfg_base;
   logic            cfg_load;
   logic [N*DW-1:0] req_word;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [AW-1:0]   mem_wr_addr;
   logic [DW-1:0]   mem_wr_data;
   logic            mem_wr_valid;
   logic            mem_wr_ready;
   logic            phase_done;
`ifdef UPD_ARB_STATS_EN
   logic [N*32-1:0] stat_words;
   logic [31:0]     stat_stalls;
`endif

   upd_wr_arbiter #(
      .N_REQ     (N),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .BURST_LEN (BL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_base     (cfg_base),
      .cfg_load     (cfg_load),
      .req_word     (req_word),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_ready (mem_wr_ready),
      .phase_done   (phase_done)
`ifdef UPD_ARB_STATS_EN
      ,
      .stat_words   (stat_words),
      .stat_stalls  (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } src_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      int              pre;
      logic [N-1:0]    mask;
      int              n;
      logic [3:0][1:0] order;
   } vec_t;

   src_t          src_q [N][$];
   exp_t          exp_q [$];
   int            hs_cyc [$];
   logic [AW-1:0] mptr [N];
   int            src_seq [N];
   int            exp_seq [N];
   vec_t          vt [6];

   int checks     = 0;
   int errors     = 0;
   int cyc        = 0;
   int stall_left = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid[i]          = 1'b1;
            req_word[i*DW +: DW]  = src_q[i][0].data;
            req_last[i]           = src_q[i][0].last;
         end else begin
            req_valid[i]          = 1'b0;
            req_word[i*DW +: DW]  = '0;
            req_last[i]           = 1'b0;
         end
      end
   endtask

   // Monitor on the falling edge, then step one rising edge and drive.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      if (mem_wr_valid && mem_wr_ready) begin
         hs_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%0h data=%0h required=none", mem_wr_addr, mem_wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
            check("wr_data", mem_wr_data, e.data);
         end
      end else if (mem_wr_valid && !mem_wr_ready) begin
         check("stall_req_ready", 64'(req_ready), 64'd0);
         if (exp_q.size() > 0) begin
            check("stall_addr", 64'(mem_wr_addr), 64'(exp_q[0].addr));
            check("stall_data", mem_wr_data, exp_q[0].data);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) begin
            void'(src_q[i].pop_front());
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (stall_left > 0) begin
         mem_wr_ready = 1'b0;
         stall_left--;
      end else begin
         mem_wr_ready = 1'b1;
      end
      drive_inputs();
   endtask

   task automatic start_stall(input int n);
      mem_wr_ready = 1'b0;
      stall_left   = n - 1;
   endtask

   task automatic push_src(input int r, input int n, input int last_at);
      src_t s;
      for (int k = 1; k <= n; k++) begin
         s.data = {32'(r), 32'(src_seq[r])};
         s.last = (k == last_at);
         src_q[r].push_back(s);
         src_seq[r]++;
      end
   endtask

   task automatic push_exp(input int r, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.addr = mptr[r];
         e.data = {32'(r), 32'(exp_seq[r])};
         exp_q.push_back(e);
         mptr[r] = mptr[r] + 1'b1;
         exp_seq[r]++;
      end
   endtask

   task automatic do_load(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                          input logic [AW-1:0] b2, input logic [AW-1:0] b3);
      cfg_base = {b3, b2, b1, b0};
      mptr[0] = b0;
      mptr[1] = b1;
      mptr[2] = b2;
      mptr[3] = b3;
      cfg_load = 1'b1;
      cycle();
      cfg_load = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mem_wr_valid) && n < budget) begin
         cycle();
         n++;
      end
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      repeat (4) cycle();
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n;
      n = 0;
      while (!mem_wr_valid && n < budget) begin
         cycle();
         n++;
      end
      check({name, "_valid_seen"}, 64'(mem_wr_valid), 64'd1);
   endtask

   task automatic flush();
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         src_seq[i] = 0;
         exp_seq[i] = 0;
         mptr[i]    = '0;
      end
   endtask

   task automatic set_vec(input int v, input int pre, input logic [N-1:0] mask, input int n,
                          input logic [1:0] o0, input logic [1:0] o1,
                          input logic [1:0] o2, input logic [1:0] o3);
      vt[v].pre      = pre;
      vt[v].mask     = mask;
      vt[v].n        = n;
      vt[v].order[0] = o0;
      vt[v].order[1] = o1;
      vt[v].order[2] = o2;
      vt[v].order[3] = o3;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cycles=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // rr_ptr after the single "pre" word is pre+1; order lists the grants
      // expected for one word from every requester in mask.
      set_vec(0, 0, 4'b1111, 4, 2'd1, 2'd2, 2'd3, 2'd0);
      set_vec(1, 1, 4'b0011, 2, 2'd0, 2'd1, 2'd0, 2'd0);
      set_vec(2, 2, 4'b1010, 2, 2'd3, 2'd1, 2'd0, 2'd0);
      set_vec(3, 3, 4'b1001, 2, 2'd0, 2'd3, 2'd0, 2'd0);
      set_vec(4, 1, 4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0);
      set_vec(5, 2, 4'b0101, 2, 2'd0, 2'd2, 2'd0, 2'd0);

      rst          = 1'b1;
      cfg_load     = 1'b0;
      cfg_base     = '0;
      req_word     = '0;
      req_valid    = '0;
      req_last     = '0;
      mem_wr_ready = 1'b1;
      flush();

      // Reset state
      repeat (3) cycle();
      check("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
      check("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
      check("rst_wr_data", mem_wr_data, 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_phase_done", 64'(phase_done), 64'd0);
      rst = 1'b0;
      cycle();

      // Round-robin order table
      for (int v = 0; v < 6; v++) begin
         do_load(32'h0, 32'h10, 32'h20, 32'h30);
         push_src(vt[v].pre, 1, 0);
         push_exp(vt[v].pre, 1);
         drive_inputs();
         drain(40, "vec_pre");
         for (int i = 0; i < N; i++) begin
            if (vt[v].mask[i]) push_src(i, 1, 0);
         end
         for (int k = 0; k < vt[v].n; k++) begin
            push_exp(int'(vt[v].order[k]), 1);
         end
         drive_inputs();
         drain(60, "vec_order");
      end

      // Single requester 0, 12 words, others finish first with one word each
      do_load(32'h1000, 32'h2000, 32'h3000, 32'h4000);
      check("t1_done_low", 64'(phase_done), 64'd0);
      for (int i = 1; i < N; i++) push_src(i, 1, 1);
      push_exp(1, 1);
      push_exp(2, 1);
      push_exp(3, 1);
      drive_inputs();
      drain(60, "t1_pre");
      hs_cyc.delete();
      push_src(0, 12, 12);
      push_exp(0, 12);
      drive_inputs();
      drain(80, "t1_main");
      check("t1_hs_count", 64'(hs_cyc.size()), 64'd12);
      if (hs_cyc.size() == 12) begin
         check("t1_burst1_span", 64'(hs_cyc[7] - hs_cyc[0]), 64'd7);
         check("t1_bubble", 64'(hs_cyc[8] - hs_cyc[7]), 64'd2);
         check("t1_burst2_span", 64'(hs_cyc[11] - hs_cyc[8]), 64'd3);
      end
      n = 0;
      while (!phase_done && n < 10) begin
         cycle();
         n++;
      end
      check("t1_phase_done", 64'(phase_done), 64'd1);
      check("t1_done_ready", 64'(req_ready), 64'd0);

      // Two always-valid requesters alternate bursts, with a 5-cycle stall
      do_load(32'h0, 32'h100, 32'h200, 32'h300);
      check("t2_done_cleared", 64'(phase_done), 64'd0);
      push_src(0, 16, 16);
      push_src(1, 16, 16);
      push_exp(0, 8);
      push_exp(1, 8);
      push_exp(0, 8);
      push_exp(1, 8);
      drive_inputs();
      wait_valid(20, "t2");
      repeat (2) cycle();
      start_stall(5);
      drain(120, "t2");

      // Requester 2 ends its phase on the 3rd word and is not regranted
      do_load(32'h0, 32'h100, 32'h200, 32'h300);
      push_src(2, 5, 3);
      push_src(3, 2, 0);
      push_exp(2, 3);
      push_exp(3, 2);
      drive_inputs();
      drain(60, "t4");
      repeat (10) cycle();
      check("t4_req2_held", 64'(src_q[2].size()), 64'd2);
      check("t4_idle_ready", 64'(req_ready), 64'd0);
      do_load(32'h0, 32'h100, 32'h200, 32'h300);
      push_exp(2, 2);
      drive_inputs();
      drain(40, "t4_reload");

      // Address wrap, then reset in the middle of a burst
      do_load(32'hFFFF_FFFE, 32'h500, 32'h600, 32'h700);
      push_src(0, 4, 0);
      push_exp(0, 4);
      drive_inputs();
      drain(40, "t5_wrap");
      push_src(1, 8, 0);
      push_exp(1, 8);
      drive_inputs();
      wait_valid(20, "t5");
      cycle();
      rst = 1'b1;
      cycle();
      check("t5_rst_wr_valid", 64'(mem_wr_valid), 64'd0);
      check("t5_rst_wr_addr", 64'(mem_wr_addr), 64'd0);
      check("t5_rst_req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      flush();
      drive_inputs();
      cycle();
      check("t5_post_rst_done", 64'(phase_done), 64'd0);
      check("t5_post_rst_valid", 64'(mem_wr_valid), 64'd0);

`ifdef UPD_ARB_STATS_EN
      // Statistics: 20 words from requester 1 with 3 stall cycles
      do_load(32'h0, 32'h600, 32'h0, 32'h0);
      push_src(1, 20, 20);
      push_exp(1, 20);
      drive_inputs();
      wait_valid(20, "t6");
      start_stall(3);
      drain(100, "t6");
      check("t6_stat_words1", 64'(stat_words[63:32]), 64'd20);
      check("t6_stat_words0", 64'(stat_words[31:0]), 64'd0);
      check("t6_stat_stalls", 64'(stat_stalls), 64'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/upd_wr_arbiter.md
# upd_wr_arbiter

Round-robin scheduler that shares the single off-chip update-write port among N_REQ scatter-engine update streams, each already serialized to one 64-bit update per cycle. It grants one requester at a time for a burst of up to BURST_LEN words, generates per-requester sequential write addresses into that requester's update bin, and reports when every requester has finished the current scatter phase. It sits between the per-PE update serializers and the memory write channel.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 64, update word width
- ADDR_W, 32, word address width (address unit = one DATA_W word)
- BURST_LEN, 8, maximum words per grant (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- cfg_base  in  N_REQ*ADDR_W  per-requester bin base address, slice i = requester i
- cfg_load  in  1  pulse: load cfg_base into write pointers, clear phase state
- req_word  in  N_REQ*DATA_W  update word per requester
- req_valid  in  N_REQ  word valid
- req_last  in  N_REQ  qualifies accepted word as the final one of the phase
- req_ready  out  N_REQ  word accepted when valid&ready
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  DATA_W  write data
- mem_wr_valid  out  1  write request valid
- mem_wr_ready  in  1  memory accepts write
- phase_done  out  1  all requesters delivered last and output drained

## Operation
- FSM: IDLE → GRANT → IDLE; DONE entered from IDLE when all requesters finished and mem_wr_valid=0.
- IDLE: eligible = req_valid & ~finished. Pick first eligible at or after rr_ptr (wrapping). Register gnt, burst_cnt=0, go to GRANT. No eligible: stay.
- GRANT: req_ready[gnt] = (!mem_wr_valid | mem_wr_ready); all other req_ready 0. On accept: mem_wr_data ← word, mem_wr_addr ← wr_ptr[gnt], mem_wr_valid ← 1, wr_ptr[gnt] += 1 (mod 2^ADDR_W), burst_cnt += 1.
- Burst ends (→ IDLE, rr_ptr ← gnt+1 mod N_REQ) on the cycle of: BURST_LEN-th accept; accepted word with req_last (finished[gnt] ← 1); or req_valid[gnt]=0 while output slot free.
- Output register: when mem_wr_valid & mem_wr_ready and no new accept, mem_wr_valid ← 0. Output holds stable while valid & !ready.
- DONE: phase_done=1, all req_ready 0; held until cfg_load or rst.
- cfg_load honoured only in IDLE or DONE with mem_wr_valid=0: wr_ptr[i] ← cfg_base[i], finished ← 0, rr_ptr ← 0, → IDLE. Ignored in GRANT or with a pending write.

## Timing
- Reset values: mem_wr_valid 0, mem_wr_addr 0, mem_wr_data 0, req_ready 0, phase_done 0; wr_ptr 0, finished 0, rr_ptr 0, state IDLE.
- Arbitration: 1 cycle (IDLE) per grant; requester word accepted at cycle t appears on mem_wr_* at t+1.
- Steady state under a full burst: BURST_LEN words per BURST_LEN+1 cycles.
- req_ready is combinational in mem_wr_ready (one-deep pipeline, no bubble under continuous ready).
- Reset mid-burst: pending output write dropped, all state to reset values next cycle.
- req_valid and req_last from a non-granted requester are ignored (no accept, finished unchanged).

## Configuration
- UPD_ARB_STATS_EN defined: adds per-requester 32-bit word counters (cleared on cfg_load/rst) and a 32-bit stall counter (cycles with mem_wr_valid & !mem_wr_ready), exposed on outputs stat_words (N_REQ*32) and stat_stalls (32); counters saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: state enum (IDLE, GRANT, DONE), DATA_W/ADDR_W defaults, stat counter width.
- One sub-module: rr_pick (combinational round-robin first-eligible finder from eligible mask and rr_ptr, returns index and any-flag).

## Test plan
- Single requester 0, base 0x1000, 12 continuous words, ready=1 → addrs 0x1000..0x1007, one bubble, 0x1008..0x100B; last on word 12 → phase_done after drain (others preset finished via their own last).
- Requesters 0 and 1 always valid, base 0x0/0x100 → alternating bursts of 8: 0x0–0x7, 0x100–0x107, 0x8–0xF, …
- mem_wr_ready low 5 cycles mid-burst → mem_wr_addr/data frozen, req_ready 0, no words lost or duplicated.
- Requester 2 asserts last on 3rd word of burst → grant released after that word, requester 2 never granted again until cfg_load.
- Base 0xFFFFFFFE, 4 words → addrs 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; rst asserted mid-burst → mem_wr_valid 0 next cycle.
- UPD_ARB_STATS_EN: 20 words from req 1 with 3 stall cycles → stat_words[1]=20, stat_stalls=3.
